block_align: RTL and testbench

Block-floating-point alignment stage for the SD4 MAC datapath: it converts floating-point operands into fixed-point values that share one exponent. It collects a group of N operands (sign, 11-bit normalized mantissa with hidden bit, signed exponent), finds the group's maximum exponent, then streams out each operand as a 20-bit two's-complement value aligned to that exponent. It is the inverse of the stage-4 normalization: if `signed_sum` and `exp_max` from this block are fed straight into normalization, the result is the original operand, apart from alignment rounding.

---
 rtl/block_align.sv | 122 ++++++++++++
 tb/tb_block_align.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/block_align.sv
// rtl/block_align.sv - block-floating-point alignment: collect N operands, share the max exponent, stream aligned values
module block_align #(
   parameter int N = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [10:0] in_mant,
   input  logic [6:0]  in_exp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [19:0] signed_sum,
   output logic [5:0]  exp_max,
   output logic        out_last
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0]      LAST    = CW'(N - 1);
   localparam logic signed [5:0]  EXP_MIN = 6'b100000;
   localparam logic signed [5:0]  EXP_TOP = 6'b011111;

   typedef enum logic {FILL, DRAIN} state_t;

   state_t              state_q;
   logic [CW-1:0]       wr_cnt_q, rd_cnt_q;
   logic                sign_q [N];
   logic [10:0]         mant_q [N];
   logic signed [5:0]   exp_q  [N];
   logic signed [5:0]   run_max_q, run_max_d, exp_max_q;
   logic signed [6:0]   in_exp_s;
   logic signed [5:0]   exp_c;

   assign in_exp_s = in_exp;

   always_comb begin
      if (in_exp_s > 7'sd31)
         exp_c = EXP_TOP;
      else if (in_exp_s < -7'sd32)
         exp_c = EXP_MIN;
      else
         exp_c = in_exp_s[5:0];
   end

   // Zero operands never raise the maximum; starting at EXP_MIN covers the all-zero group.
   assign run_max_d = ((in_mant != 11'd0) && (exp_c > run_max_q)) ? exp_c : run_max_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= FILL;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         run_max_q <= EXP_MIN;
         exp_max_q <= EXP_MIN;
         for (int i = 0; i < N; i++) begin
            sign_q[i] <= 1'b0;
            mant_q[i] <= '0;
            exp_q[i]  <= '0;
         end
      end else begin
         case (state_q)
            FILL: begin
               if (in_valid) begin
                  sign_q[wr_cnt_q] <= in_sign;
                  mant_q[wr_cnt_q] <= in_mant;
                  exp_q[wr_cnt_q]  <= exp_c;
                  if (wr_cnt_q == LAST) begin
                     exp_max_q <= run_max_d;
                     run_max_q <= EXP_MIN;
                     wr_cnt_q  <= '0;
                     state_q   <= DRAIN;
                  end else begin
                     run_max_q <= run_max_d;
                     wr_cnt_q  <= wr_cnt_q + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (rd_cnt_q == LAST) begin
                     rd_cnt_q <= '0;
                     state_q  <= FILL;
                  end else begin
                     rd_cnt_q <= rd_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign in_ready  = (state_q == FILL);
   assign out_valid = (state_q == DRAIN);
   assign out_last  = (state_q == DRAIN) && (rd_cnt_q == LAST);
   assign exp_max   = exp_max_q;

   logic signed [6:0] diff;
   logic [22:0]       wide;
   logic [11:0]       mag;
   logic [10:0]       cur_mant;
   logic              cur_sign;

   assign cur_mant = mant_q[rd_cnt_q];
   assign cur_sign = sign_q[rd_cnt_q];
   assign diff     = {exp_max_q[5], exp_max_q} - {exp_q[rd_cnt_q][5], exp_q[rd_cnt_q]};

   // Low 12 bits of wide hold the shifted-out fraction: bit 11 is the half, below it the sticky.
   always_comb begin
      wide = '0;
      mag  = '0;
      if ((cur_mant != 11'd0) && (diff >= 7'sd0) && (diff < 7'sd12)) begin
         wide = {cur_mant, 12'd0} >> diff[3:0];
         mag  = {1'b0, wide[22:12]}
              + {11'd0, wide[11] & ((|wide[10:0]) | wide[12])};
      end
   end

   assign signed_sum = cur_sign ? (20'd0 - {8'd0, mag}) : {8'd0, mag};

endmodule

// File: tb/tb_block_align.sv
// tb/tb_block_align.sv - directed self-checking bench for block_align
module tb_block_align;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_sign;
   logic [10:0] in_mant;
   logic [6:0]  in_exp;
   logic        out_ready;
   logic        in_ready;
   logic        out_valid;
   logic [19:0] signed_sum;
   logic [5:0]  exp_max;
   logic        out_last;

   int checks   = 0;
   int failures = 0;

   logic signed [19:0] got_sum [4];
   logic [5:0]         got_exp [4];
   logic [3:0]         got_last;
   logic [3:0]         got_valid;

   block_align #(.N(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
      .in_mant(in_mant), .in_exp(in_exp),
      .out_valid(out_valid), .out_ready(out_ready),
      .signed_sum(signed_sum), .exp_max(exp_max), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic push(input logic s, input int m, input int e);
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = s;
      in_mant  = 11'(m);
      in_exp   = 7'(e);
   endtask

   task automatic drain(input int first, input int count);
      for (int i = first; i < first + count; i++) begin
         @(negedge clk);
         in_valid  = 1'b0;
         out_ready = 1'b1;
         #1;
         got_sum[i]   = signed_sum;
         got_exp[i]   = exp_max;
         got_last[i]  = out_last;
         got_valid[i] = out_valid;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_mant = '0; in_exp = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
      checks++; if (exp_max !== 6'h20) begin failures++; $display("FAIL reset_exp_max got=%h exp=20", exp_max); end
      checks++; if (signed_sum !== 20'd0) begin failures++; $display("FAIL reset_sum got=%h exp=0", signed_sum); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      logic signed [19:0] es [4];
      es = '{20'sd1024, 20'sd1024, -20'sd768, 20'sd0};
      push(0, 1024, 3); push(0, 1024, 3); push(1, 1536, 2); push(1, 0, 20);
      drain(0, 4);
      for (int i = 0; i < 4; i++) begin
         checks++; if (got_sum[i] !== es[i]) begin failures++; $display("FAIL basic_sum%0d got=%0d exp=%0d", i, got_sum[i], es[i]); end
         checks++; if (got_exp[i] !== 6'd3) begin failures++; $display("FAIL basic_exp%0d got=%0d exp=3", i, got_exp[i]); end
      end
      checks++; if (got_last !== 4'b1000) begin failures++; $display("FAIL basic_last got=%b exp=1000", got_last); end
      checks++; if (got_valid !== 4'b1111) begin failures++; $display("FAIL basic_valid got=%b exp=1111", got_valid); end
   endtask

   task automatic test_round();
      logic signed [19:0] es [4];
      es = '{20'sd2047, 20'sd257, 20'sd256, 20'sd258};
      push(0, 2047, 5); push(0, 1027, 3); push(0, 1026, 3); push(0, 1030, 3);
      drain(0, 4);
      for (int i = 0; i < 4; i++) begin
         checks++; if (got_sum[i] !== es[i]) begin failures++; $display("FAIL round1_sum%0d got=%0d exp=%0d", i, got_sum[i], es[i]); end
      end
      checks++; if (got_exp[0] !== 6'd5) begin failures++; $display("FAIL round1_exp got=%0d exp=5", got_exp[0]); end
      es = '{-20'sd2047, 20'sd0, 20'sd1, 20'sd0};
      push(1, 2047, 5); push(0, 2047, -7); push(0, 1025, -6); push(0, 1024, -6);
      drain(0, 4);
      for (int i = 0; i < 4; i++) begin
         checks++; if (got_sum[i] !== es[i]) begin failures++; $display("FAIL round2_sum%0d got=%0d exp=%0d", i, got_sum[i], es[i]); end
      end
      checks++; if (got_exp[3] !== 6'd5) begin failures++; $display("FAIL round2_exp got=%0d exp=5", got_exp[3]); end
   endtask

   task automatic test_all_zero();
      push(0, 0, 7); push(1, 0, -3); push(1, 0, 25); push(0, 0, 0);
      drain(0, 4);
      for (int i = 0; i < 4; i++) begin
         checks++; if (got_sum[i] !== 20'sd0) begin failures++; $display("FAIL zero_sum%0d got=%0d exp=0", i, got_sum[i]); end
      end
      checks++; if (got_exp[0] !== 6'h20) begin failures++; $display("FAIL zero_exp got=%h exp=20", got_exp[0]); end
   endtask

   task automatic test_clamp();
      logic signed [19:0] es [4];
      es = '{20'sd1024, 20'sd1024, 20'sd0, 20'sd0};
      push(0, 1024, 40); push(0, 1024, 31); push(0, 1024, -50); push(0, 1024, -32);
      drain(0, 4);
      checks++; if (got_exp[0] !== 6'd31) begin failures++; $display("FAIL clamp1_exp got=%0d exp=31", got_exp[0]); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (got_sum[i] !== es[i]) begin failures++; $display("FAIL clamp1_sum%0d got=%0d exp=%0d", i, got_sum[i], es[i]); end
      end
      push(0, 1024, -50); push(0, 1024, -40); push(0, 1024, -33); push(0, 1024, -32);
      drain(0, 4);
      checks++; if (got_exp[0] !== 6'h20) begin failures++; $display("FAIL clamp2_exp got=%h exp=20", got_exp[0]); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (got_sum[i] !== 20'sd1024) begin failures++; $display("FAIL clamp2_sum%0d got=%0d exp=1024", i, got_sum[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic signed [19:0] es [4];
      es = '{20'sd1024, -20'sd1024, 20'sd512, 20'sd256};
      push(0, 1024, 0); push(1, 1024, 0); push(0, 1024, -1); push(0, 1024, -2);
      drain(0, 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         out_ready = 1'b0; in_valid = 1'b1; in_sign = 1'b0; in_mant = 11'd2047; in_exp = 7'd31;
         #1;
         checks++; if (signed_sum !== 20'hFFC00) begin failures++; $display("FAIL bp_hold_sum%0d got=%0d exp=-1024", c, $signed(signed_sum)); end
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_last !== 1'b0 || exp_max !== 6'd0) begin
            failures++; $display("FAIL bp_hold_ctl%0d got=%b%b%b_%0d exp=010_0", c, in_ready, out_valid, out_last, exp_max);
         end
      end
      drain(1, 3);
      for (int i = 0; i < 4; i++) begin
         checks++; if (got_sum[i] !== es[i]) begin failures++; $display("FAIL bp_sum%0d got=%0d exp=%0d", i, got_sum[i], es[i]); end
      end
      checks++; if (got_last !== 4'b1000) begin failures++; $display("FAIL bp_last got=%b exp=1000", got_last); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_after got=%b%b exp=10", in_ready, out_valid); end
      push(0, 1024, 1); push(0, 1024, 1); push(0, 1024, 1); push(0, 1024, 1);
      drain(0, 4);
      checks++; if (got_exp[0] !== 6'd1 || got_sum[3] !== 20'sd1024) begin
         failures++; $display("FAIL bp_next got=%0d/%0d exp=1/1024", got_exp[0], got_sum[3]);
      end
   endtask

   task automatic test_reset_mid();
      logic signed [19:0] es [4];
      es = '{20'sd1024, 20'sd512, 20'sd256, 20'sd1024};
      push(0, 1024, 31); push(0, 1024, 31);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || exp_max !== 6'h20) begin
         failures++; $display("FAIL rstmid got=%b%b_%h exp=10_20", in_ready, out_valid, exp_max);
      end
      @(negedge clk);
      rst = 1'b1;
      push(0, 1024, 2); push(0, 1024, 1); push(0, 1024, 0); push(0, 1024, 2);
      drain(0, 4);
      checks++; if (got_exp[0] !== 6'd2) begin failures++; $display("FAIL rstmid_exp got=%0d exp=2", got_exp[0]); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (got_sum[i] !== es[i]) begin failures++; $display("FAIL rstmid_sum%0d got=%0d exp=%0d", i, got_sum[i], es[i]); end
      end
      checks++; if (got_last !== 4'b1000) begin failures++; $display("FAIL rstmid_last got=%b exp=1000", got_last); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round();
      test_all_zero();
      test_clamp();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
